rf_writeback: RTL

//  Write-side front end for the 32-entry register file.
//  - Collects results from two producers, the ALU and the load/store unit (LSU), via valid/ready handshakes.
//  - Buffers accepted results in a small in-order FIFO.
//  - Drains at most one write per cycle onto the regfile write port (RF_WE / w_adr / w_data).
//  - Exports a per-register pending vector so issue logic can stall on RAW hazards against writes still queued.
//

---
 rtl/rf_writeback_if.sv | 34 +++
 rtl/rf_writeback.sv | 112 +++++++++++
 2 files changed

// File: rtl/rf_writeback_if.sv
// Producer handshakes and regfile write-port signals of the writeback front end.
// The master side drives results in; the slave side (rf_writeback) answers.
interface rf_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 1 << ADDR_W;

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              RF_WE;
  logic [ADDR_W-1:0] w_adr;
  logic [DATA_W-1:0] w_data;
  logic [NREG-1:0]   pending;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, RF_WE, w_adr, w_data, pending, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, RF_WE, w_adr, w_data, pending, fifo_count
  );
endinterface

// File: rtl/rf_writeback.sv
// Register-file write front end: arbitrates ALU/LSU results (LSU first) into an
// in-order FIFO, drains one write per cycle and exports a RAW pending vector.
module rf_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  rf_writeback_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 1 << ADDR_W;

  logic [ADDR_W-1:0] rd_mem_q   [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              full_s;
  logic              pop_s;
  logic              push_s;
  logic [ADDR_W-1:0] push_rd_s;
  logic [DATA_W-1:0] push_data_s;
  logic [PTR_W-1:0]  off_s;
  logic [NREG-1:0]   pending_s;

  // Enqueue arbitration: LSU wins; an accepted x0 write completes its handshake but is dropped.
  always_comb begin
    full_s      = (count_q == CNT_W'(DEPTH));
    pop_s       = (count_q != '0);
    push_s      = 1'b0;
    push_rd_s   = '0;
    push_data_s = '0;
    if (bus.lsu_valid && !full_s) begin
      push_s      = (bus.lsu_rd != '0);
      push_rd_s   = bus.lsu_rd;
      push_data_s = bus.lsu_data;
    end else if (bus.alu_valid && !full_s) begin
      push_s      = (bus.alu_rd != '0);
      push_rd_s   = bus.alu_rd;
      push_data_s = bus.alu_data;
    end else begin
      push_s      = 1'b0;
    end
  end

  // Next-state for pointers, occupancy and the registered write port.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    we_d     = pop_s;
    adr_d    = pop_s ? rd_mem_q[rd_ptr_q]   : adr_q;
    data_d   = pop_s ? data_mem_q[rd_ptr_q] : data_q;
  end

  // Control state and write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      data_q   <= data_d;
    end
  end

  // Entry storage; validity comes from the pointers and count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      rd_mem_q[wr_ptr_q]   <= push_rd_s;
      data_mem_q[wr_ptr_q] <= push_data_s;
    end else begin
      rd_mem_q[wr_ptr_q]   <= rd_mem_q[wr_ptr_q];
      data_mem_q[wr_ptr_q] <= data_mem_q[wr_ptr_q];
    end
  end

  // Pending vector: an entry is live when its distance from the head is below the count.
  always_comb begin
    pending_s = '0;
    off_s     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off_s = PTR_W'(i) - rd_ptr_q;
      pending_s[rd_mem_q[i]] = pending_s[rd_mem_q[i]] | ({1'b0, off_s} < count_q);
    end
    pending_s[adr_q] = pending_s[adr_q] | we_q;
    pending_s[0]     = 1'b0;
  end

  assign bus.lsu_ready  = !full_s;
  assign bus.alu_ready  = !full_s && !bus.lsu_valid;
  assign bus.RF_WE      = we_q;
  assign bus.w_adr      = adr_q;
  assign bus.w_data     = data_q;
  assign bus.pending    = pending_s;
  assign bus.fifo_count = count_q;
endmodule
